// File: rtl/dsp_mac_stream.sv
// Streaming DSP slice: signed pre-adder, multiplier and post-adder/accumulator in a
// three-stage pipeline with valid/ready flow control, accumulate-and-dump and optional saturation.
module dsp_mac_stream #(
   parameter int A_W      = 18,
   parameter int B_W      = 18,
   parameter int D_W      = 18,
   parameter int C_W      = 48,
   parameter int P_W      = 48,
   parameter int ACC_LEN  = 16,
   parameter int SATURATE = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_in_valid,
   output logic                  o_in_ready,
   input  logic signed [A_W-1:0] i_a,
   input  logic signed [B_W-1:0] i_b,
   input  logic signed [D_W-1:0] i_d,
   input  logic signed [C_W-1:0] i_c,
   input  logic [3:0]            i_opmode,
   input  logic                  i_flush,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic signed [P_W-1:0] o_p,
   output logic                  o_ovf,
   output logic [15:0]           o_acc_cnt
);

   localparam int BD_W  = (B_W > D_W) ? B_W : D_W;
   localparam int PRE_W = BD_W + 1;
   localparam int M_W   = A_W + PRE_W;
   localparam int R_W   = P_W + 1;
   localparam logic [15:0] ACC_LEN_C = 16'(ACC_LEN);

   localparam logic [1:0] POST_M   = 2'b00;
   localparam logic [1:0] POST_CPM = 2'b01;
   localparam logic [1:0] POST_ACC = 2'b10;
   localparam logic [1:0] POST_CMM = 2'b11;

   if (P_W < M_W || P_W < C_W) begin : g_bad_width
      $error("dsp_mac_stream: P_W too narrow for the product or C operand");
   end
   if (ACC_LEN < 1 || ACC_LEN > 65535) begin : g_bad_acc_len
      $error("dsp_mac_stream: ACC_LEN out of range 1..65535");
   end

   logic w_stall;
   logic w_accept;

   // Stage 1: operand capture and pre-add
   logic signed [PRE_W-1:0] w_b_ext;
   logic signed [PRE_W-1:0] w_d_ext;
   logic signed [PRE_W-1:0] w_pre;

   logic                    r_v1;
   logic signed [A_W-1:0]   r_a1;
   logic signed [PRE_W-1:0] r_pre1;
   logic signed [C_W-1:0]   r_c1;
   logic [1:0]              r_post1;
   logic                    r_flush1;

   // Stage 2: multiply
   logic [M_W-1:0]          w_m;
   logic                    r_v2;
   logic [M_W-1:0]          r_m2;
   logic signed [C_W-1:0]   r_c2;
   logic [1:0]              r_post2;
   logic                    r_flush2;

   // Stage 3: post-add / accumulate
   logic signed [R_W-1:0]   w_m_ext;
   logic signed [R_W-1:0]   w_c_ext;
   logic signed [R_W-1:0]   w_acc_ext;
   logic signed [R_W-1:0]   w_res;
   logic                    w_ovf;
   logic signed [P_W-1:0]   w_clip;
   logic                    w_is_acc;
   logic [15:0]             w_cnt_nxt;
   logic                    w_dump;
   logic                    w_ovf_sticky;

   logic                    r_out_valid;
   logic signed [P_W-1:0]   r_p;
   logic                    r_ovf;
   logic signed [P_W-1:0]   r_acc;
   logic [15:0]             r_acc_cnt;
   logic                    r_acc_ovf;

   assign w_stall    = r_out_valid & ~i_out_ready;
   assign o_in_ready = ~w_stall;
   assign w_accept   = i_in_valid & o_in_ready;

   assign w_b_ext = {{(PRE_W-B_W){i_b[B_W-1]}}, i_b};
   assign w_d_ext = {{(PRE_W-D_W){i_d[D_W-1]}}, i_d};

   always_comb begin
      w_pre = w_b_ext;
      if (i_opmode[0]) begin
         w_pre = i_opmode[1] ? (w_d_ext - w_b_ext) : (w_d_ext + w_b_ext);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_v1     <= 1'b0;
         r_a1     <= '0;
         r_pre1   <= '0;
         r_c1     <= '0;
         r_post1  <= POST_M;
         r_flush1 <= 1'b0;
      end else if (!w_stall) begin
         r_v1 <= w_accept;
         if (w_accept) begin
            r_a1     <= i_a;
            r_pre1   <= w_pre;
            r_c1     <= i_c;
            r_post1  <= i_opmode[3:2];
            r_flush1 <= i_flush;
         end
      end
   end

   // Both factors sign-extended to the full product width, so the low M_W bits are exact
   assign w_m = {{PRE_W{r_a1[A_W-1]}}, r_a1} * {{A_W{r_pre1[PRE_W-1]}}, r_pre1};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_v2     <= 1'b0;
         r_m2     <= '0;
         r_c2     <= '0;
         r_post2  <= POST_M;
         r_flush2 <= 1'b0;
      end else if (!w_stall) begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_m2     <= w_m;
            r_c2     <= r_c1;
            r_post2  <= r_post1;
            r_flush2 <= r_flush1;
         end
      end
   end

   assign w_m_ext   = {{(R_W-M_W){r_m2[M_W-1]}}, r_m2};
   assign w_c_ext   = {{(R_W-C_W){r_c2[C_W-1]}}, r_c2};
   assign w_acc_ext = {r_acc[P_W-1], r_acc};

   always_comb begin
      case (r_post2)
         POST_M:   w_res = w_m_ext;
         POST_CPM: w_res = w_c_ext + w_m_ext;
         POST_CMM: w_res = w_c_ext - w_m_ext;
         default:  w_res = w_acc_ext + w_m_ext;
      endcase
   end

   // Every operand fits in P_W bits, so one guard bit keeps the sum exact for the overflow test
   assign w_ovf = w_res[R_W-1] ^ w_res[R_W-2];

   always_comb begin
      w_clip = w_res[P_W-1:0];
      if (w_ovf && SATURATE != 0) begin
         w_clip = w_res[R_W-1] ? {1'b1, {(P_W-1){1'b0}}} : {1'b0, {(P_W-1){1'b1}}};
      end
   end

   assign w_is_acc     = (r_post2 == POST_ACC);
   assign w_cnt_nxt    = r_acc_cnt + 16'd1;
   assign w_dump       = (w_cnt_nxt == ACC_LEN_C) | r_flush2;
   assign w_ovf_sticky = r_acc_ovf | w_ovf;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_out_valid <= 1'b0;
         r_p         <= '0;
         r_ovf       <= 1'b0;
         r_acc       <= '0;
         r_acc_cnt   <= '0;
         r_acc_ovf   <= 1'b0;
      end else if (!w_stall) begin
         r_out_valid <= 1'b0;
         if (r_v2) begin
            if (w_is_acc && !w_dump) begin
               r_acc     <= w_clip;
               r_acc_cnt <= w_cnt_nxt;
               r_acc_ovf <= w_ovf_sticky;
            end else begin
               // Dumps and non-accumulate samples both close any open window
               r_out_valid <= 1'b1;
               r_p         <= w_clip;
               r_ovf       <= w_is_acc ? w_ovf_sticky : w_ovf;
               r_acc       <= '0;
               r_acc_cnt   <= '0;
               r_acc_ovf   <= 1'b0;
            end
         end
      end
   end

   assign o_out_valid = r_out_valid;
   assign o_p         = r_p;
   assign o_ovf       = r_ovf;
   assign o_acc_cnt   = r_acc_cnt;

endmodule

// File: tb/tb_dsp_mac_stream.sv
// Directed bench for dsp_mac_stream: one saturating and one wrapping instance share stimulus,
// each scenario task drives vectors and compares against hand-computed results.
module tb_dsp_mac_stream;

   localparam int A_W = 18;
   localparam int B_W = 18;
   localparam int D_W = 18;
   localparam int C_W = 48;
   localparam int P_W = 48;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  in_valid;
   logic signed [A_W-1:0] a;
   logic signed [B_W-1:0] b;
   logic signed [D_W-1:0] d;
   logic signed [C_W-1:0] c;
   logic [3:0]            op;
   logic                  flush;
   logic                  out_ready;

   logic                  in_ready_s, out_valid_s, ovf_s;
   logic signed [P_W-1:0] p_s;
   logic [15:0]           cnt_s;
   logic                  in_ready_w, out_valid_w, ovf_w;
   logic signed [P_W-1:0] p_w;
   logic [15:0]           cnt_w;

   logic signed [P_W-1:0] qp_s[$];
   logic signed [P_W-1:0] qp_w[$];
   logic                  qo_s[$];
   logic                  qo_w[$];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dsp_mac_stream #(.A_W(A_W), .B_W(B_W), .D_W(D_W), .C_W(C_W), .P_W(P_W),
                    .ACC_LEN(4), .SATURATE(1)) dut_s (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready_s),
      .i_a(a), .i_b(b), .i_d(d), .i_c(c), .i_opmode(op), .i_flush(flush),
      .o_out_valid(out_valid_s), .i_out_ready(out_ready), .o_p(p_s), .o_ovf(ovf_s),
      .o_acc_cnt(cnt_s));

   dsp_mac_stream #(.A_W(A_W), .B_W(B_W), .D_W(D_W), .C_W(C_W), .P_W(P_W),
                    .ACC_LEN(4), .SATURATE(0)) dut_w (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready_w),
      .i_a(a), .i_b(b), .i_d(d), .i_c(c), .i_opmode(op), .i_flush(flush),
      .o_out_valid(out_valid_w), .i_out_ready(out_ready), .o_p(p_w), .o_ovf(ovf_w),
      .o_acc_cnt(cnt_w));

   // A transfer happens at the next rising edge when valid and ready are both high at the falling edge
   always @(negedge clk) begin
      if (rst_n && out_valid_s && out_ready) begin
         qp_s.push_back(p_s);
         qo_s.push_back(ovf_s);
      end
      if (rst_n && out_valid_w && out_ready) begin
         qp_w.push_back(p_w);
         qo_w.push_back(ovf_w);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic qclear();
      qp_s.delete(); qo_s.delete(); qp_w.delete(); qo_w.delete();
   endtask

   task automatic send(input logic signed [A_W-1:0] av, input logic signed [B_W-1:0] bv,
                       input logic signed [D_W-1:0] dv, input logic signed [C_W-1:0] cv,
                       input logic [3:0] opv, input logic fv);
      logic rdy;
      int   n;
      a = av; b = bv; d = dv; c = cv; op = opv; flush = fv;
      in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         rdy = in_ready_s;
         @(posedge clk);
         #1;
         n++;
      end while (!rdy && n < 50);
      n_cmp++;
      if (!rdy) begin
         n_bad++;
         $display("FAIL send_accept: sample not accepted within 50 cycles");
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; d = '0; c = '0; op = '0; flush = 1'b0;
      out_ready = 1'b1;
      tick(2);
      n_cmp++; if (out_valid_s !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid_s); end
      n_cmp++; if (p_s !== '0) begin n_bad++; $display("FAIL rst_p: got %0d want 0", p_s); end
      n_cmp++; if (ovf_s !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", ovf_s); end
      n_cmp++; if (cnt_s !== 16'd0 || cnt_w !== 16'd0) begin n_bad++; $display("FAIL rst_acc_cnt: got %0d/%0d want 0", cnt_s, cnt_w); end
      n_cmp++; if (in_ready_s !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready_s); end
      rst_n = 1'b1;
      tick(1);
      n_cmp++; if (in_ready_s !== 1'b1) begin n_bad++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready_s); end
   endtask

   task automatic test_latency();
      qclear();
      send(18'sd3, -18'sd4, 18'sd0, 48'sd0, 4'b0000, 1'b0);
      n_cmp++; if (out_valid_s !== 1'b0) begin n_bad++; $display("FAIL lat_cycle1: out_valid got %b want 0", out_valid_s); end
      tick(1);
      n_cmp++; if (out_valid_s !== 1'b0) begin n_bad++; $display("FAIL lat_cycle2: out_valid got %b want 0", out_valid_s); end
      tick(1);
      n_cmp++; if (out_valid_s !== 1'b1) begin n_bad++; $display("FAIL lat_cycle3: out_valid got %b want 1", out_valid_s); end
      n_cmp++; if (p_s !== -48'sd12) begin n_bad++; $display("FAIL lat_p: got %0d want -12", p_s); end
      n_cmp++; if (ovf_s !== 1'b0) begin n_bad++; $display("FAIL lat_ovf: got %b want 0", ovf_s); end
      tick(1);
      n_cmp++; if (out_valid_s !== 1'b0) begin n_bad++; $display("FAIL lat_single: out_valid got %b want 0", out_valid_s); end
   endtask

   task automatic test_preadd_post();
      logic signed [P_W-1:0] e [8];
      e = '{48'sd12, 48'sd88, 48'sd72, 48'sd112, 48'sd28, 48'sd8, 48'sd6, 48'sd36};
      qclear();
      send(18'sd2, 18'sd4, 18'sd10, 48'sd0,   4'b0011, 1'b0);
      send(18'sd2, 18'sd4, 18'sd10, 48'sd100, 4'b1111, 1'b0);
      send(18'sd2, 18'sd4, 18'sd10, 48'sd100, 4'b1101, 1'b0);
      send(18'sd2, 18'sd4, 18'sd10, 48'sd100, 4'b0111, 1'b0);
      send(18'sd2, 18'sd4, 18'sd10, 48'sd0,   4'b0001, 1'b0);
      send(18'sd2, 18'sd4, 18'sd10, 48'sd0,   4'b0010, 1'b0);
      send(-18'sd3, 18'sd5, -18'sd7, 48'sd0,  4'b0001, 1'b0);
      send(-18'sd3, 18'sd5, -18'sd7, 48'sd0,  4'b0011, 1'b0);
      tick(5);
      n_cmp++; if (qp_s.size() != 8) begin n_bad++; $display("FAIL preadd_count: got %0d want 8", qp_s.size()); end
      for (int i = 0; i < 8; i++) begin
         if (i < qp_s.size()) begin
            n_cmp++;
            if (qp_s[i] !== e[i]) begin n_bad++; $display("FAIL preadd_p[%0d]: got %0d want %0d", i, qp_s[i], e[i]); end
         end
      end
   endtask

   task automatic test_acc();
      qclear();
      repeat (3) send(18'sd1, 18'sd5, 18'sd0, 48'sd0, 4'b1000, 1'b0);
      tick(4);
      n_cmp++; if (cnt_s !== 16'd3) begin n_bad++; $display("FAIL acc_cnt3: got %0d want 3", cnt_s); end
      n_cmp++; if (qp_s.size() != 0) begin n_bad++; $display("FAIL acc_no_early_out: got %0d outputs want 0", qp_s.size()); end
      send(18'sd1, 18'sd5, 18'sd0, 48'sd0, 4'b1000, 1'b0);
      tick(4);
      n_cmp++; if (qp_s.size() != 1) begin n_bad++; $display("FAIL acc_dump_count: got %0d want 1", qp_s.size()); end
      n_cmp++; if (qp_s.size() > 0 && (qp_s[0] !== 48'sd20 || qo_s[0] !== 1'b0)) begin n_bad++; $display("FAIL acc_dump_p: got %0d ovf %b want 20 ovf 0", qp_s[0], qo_s[0]); end
      n_cmp++; if (cnt_s !== 16'd0) begin n_bad++; $display("FAIL acc_cnt_clear: got %0d want 0", cnt_s); end
      send(18'sd1, 18'sd5, 18'sd0, 48'sd0, 4'b1000, 1'b0);
      tick(4);
      n_cmp++; if (cnt_s !== 16'd1) begin n_bad++; $display("FAIL acc_cnt1: got %0d want 1", cnt_s); end
      send(18'sd1, 18'sd5, 18'sd0, 48'sd0, 4'b1000, 1'b1);
      tick(4);
      n_cmp++; if (qp_s.size() != 2) begin n_bad++; $display("FAIL flush_count: got %0d want 2", qp_s.size()); end
      n_cmp++; if (qp_s.size() > 1 && qp_s[1] !== 48'sd10) begin n_bad++; $display("FAIL flush_p: got %0d want 10", qp_s[1]); end
      n_cmp++; if (cnt_s !== 16'd0) begin n_bad++; $display("FAIL flush_cnt_clear: got %0d want 0", cnt_s); end
   endtask

   task automatic test_acc_discard();
      qclear();
      repeat (2) send(18'sd1, 18'sd5, 18'sd0, 48'sd0, 4'b1000, 1'b0);
      tick(4);
      n_cmp++; if (cnt_s !== 16'd2) begin n_bad++; $display("FAIL discard_cnt2: got %0d want 2", cnt_s); end
      send(18'sd2, 18'sd3, 18'sd0, 48'sd0, 4'b0000, 1'b1);
      repeat (4) send(18'sd1, 18'sd1, 18'sd0, 48'sd0, 4'b1000, 1'b0);
      tick(5);
      n_cmp++; if (qp_s.size() != 2) begin n_bad++; $display("FAIL discard_count: got %0d want 2", qp_s.size()); end
      n_cmp++; if (qp_s.size() > 0 && qp_s[0] !== 48'sd6) begin n_bad++; $display("FAIL discard_nonacc_p: got %0d want 6", qp_s[0]); end
      n_cmp++; if (qp_s.size() > 1 && qp_s[1] !== 48'sd4) begin n_bad++; $display("FAIL discard_new_window_p: got %0d want 4", qp_s[1]); end
   endtask

   task automatic test_overflow();
      logic signed [P_W-1:0] pmax, pmin;
      pmax = 48'sh7FFF_FFFF_FFFF;
      pmin = 48'sh8000_0000_0000;
      qclear();
      send(18'sd1, 18'sd1, 18'sd0, pmax, 4'b0100, 1'b0);
      send(18'sd1, 18'sd1, 18'sd0, pmin, 4'b1100, 1'b0);
      send(18'sd1, 18'sd1, 18'sd0, pmax - 48'sd1, 4'b0100, 1'b0);
      tick(5);
      n_cmp++; if (qp_s.size() != 3 || qp_w.size() != 3) begin n_bad++; $display("FAIL ovf_count: got %0d/%0d want 3/3", qp_s.size(), qp_w.size()); end
      if (qp_s.size() == 3 && qp_w.size() == 3) begin
         n_cmp++; if (qp_s[0] !== pmax || qo_s[0] !== 1'b1) begin n_bad++; $display("FAIL sat_pos: got %0d ovf %b want %0d ovf 1", qp_s[0], qo_s[0], pmax); end
         n_cmp++; if (qp_w[0] !== pmin || qo_w[0] !== 1'b1) begin n_bad++; $display("FAIL wrap_pos: got %0d ovf %b want %0d ovf 1", qp_w[0], qo_w[0], pmin); end
         n_cmp++; if (qp_s[1] !== pmin || qo_s[1] !== 1'b1) begin n_bad++; $display("FAIL sat_neg: got %0d ovf %b want %0d ovf 1", qp_s[1], qo_s[1], pmin); end
         n_cmp++; if (qp_w[1] !== pmax || qo_w[1] !== 1'b1) begin n_bad++; $display("FAIL wrap_neg: got %0d ovf %b want %0d ovf 1", qp_w[1], qo_w[1], pmax); end
         n_cmp++; if (qp_s[2] !== pmax || qo_s[2] !== 1'b0 || qp_w[2] !== pmax || qo_w[2] !== 1'b0) begin n_bad++; $display("FAIL edge_fit: got %0d/%0d ovf %b/%b want %0d ovf 0", qp_s[2], qp_w[2], qo_s[2], qo_w[2], pmax); end
      end
   endtask

   task automatic test_back_to_back_stall();
      qclear();
      out_ready = 1'b0;
      fork
         begin
            for (int i = 1; i <= 4; i++) send(18'(i), 18'sd7, 18'sd0, 48'sd0, 4'b0000, 1'b0);
         end
         begin
            int k;
            k = 0;
            while (!out_valid_s && k < 20) begin tick(1); k++; end
            n_cmp++; if (out_valid_s !== 1'b1) begin n_bad++; $display("FAIL stall_first_valid: got %b want 1", out_valid_s); end
            for (int j = 0; j < 5; j++) begin
               n_cmp++; if (in_ready_s !== 1'b0 || in_ready_w !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready[%0d]: got %b want 0", j, in_ready_s); end
               n_cmp++; if (p_s !== 48'sd7) begin n_bad++; $display("FAIL stall_p_hold[%0d]: got %0d want 7", j, p_s); end
               tick(1);
            end
            out_ready = 1'b1;
         end
      join
      tick(6);
      n_cmp++; if (qp_s.size() != 4) begin n_bad++; $display("FAIL stall_count: got %0d want 4", qp_s.size()); end
      for (int i = 0; i < 4; i++) begin
         if (i < qp_s.size()) begin
            n_cmp++;
            if (qp_s[i] !== 48'(7 * (i + 1))) begin n_bad++; $display("FAIL stall_order[%0d]: got %0d want %0d", i, qp_s[i], 7 * (i + 1)); end
         end
      end
   endtask

   task automatic test_reset_mid_window();
      qclear();
      repeat (3) send(18'sd1, 18'sd5, 18'sd0, 48'sd0, 4'b1000, 1'b0);
      send(18'sd1, 18'sd5, 18'sd0, 48'sd0, 4'b1000, 1'b1);
      n_cmp++; if (cnt_s !== 16'd2) begin n_bad++; $display("FAIL mid_cnt_before: got %0d want 2", cnt_s); end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid_s !== 1'b0 || cnt_s !== 16'd0) begin n_bad++; $display("FAIL mid_rst_immediate: valid %b cnt %0d want 0 0", out_valid_s, cnt_s); end
      n_cmp++; if (p_s !== '0) begin n_bad++; $display("FAIL mid_rst_p: got %0d want 0", p_s); end
      tick(2);
      rst_n = 1'b1;
      tick(5);
      n_cmp++; if (qp_s.size() != 0) begin n_bad++; $display("FAIL mid_inflight_dropped: got %0d outputs want 0", qp_s.size()); end
      repeat (4) send(18'sd1, 18'sd2, 18'sd0, 48'sd0, 4'b1000, 1'b0);
      tick(5);
      n_cmp++; if (qp_s.size() != 1) begin n_bad++; $display("FAIL mid_new_window_count: got %0d want 1", qp_s.size()); end
      n_cmp++; if (qp_s.size() > 0 && qp_s[0] !== 48'sd8) begin n_bad++; $display("FAIL mid_new_window_p: got %0d want 8", qp_s[0]); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_preadd_post();
      test_acc();
      test_acc_discard();
      test_overflow();
      test_back_to_back_stall();
      test_reset_mid_window();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
